// File: rtl/fp_convert_unsigned_pipe_pkg.sv
// fp_convert_unsigned_pipe_pkg
//   Shared types and constants for the unsigned FP32 <-> uint32 convert pipe.
//   fpu_op_t     : FPU opcode enumeration (includes FPU_CVTWUS / FPU_CVTSWU)
//   cvt_flags_t  : {nv, nx} exception flags
//   cvt_class_t  : operand class decoded in S1
package fp_convert_unsigned_pipe_pkg;

  localparam int          DATA_WIDTH        = 32;
  localparam logic [7:0]  FP32_BIAS         = 8'd127;
  localparam logic [7:0]  FP32_EXP_MAX      = 8'hFF;
  localparam logic [31:0] UINT32_MAX        = 32'hFFFF_FFFF;
  // Biased exponent of 2^32: anything at or above this saturates a uint32.
  localparam logic [7:0]  FP32_EXP_2P32     = 8'd159;
  // Biased exponent of 2^31, the exponent of a normalized uint32 with lzc=0.
  localparam logic [7:0]  FP32_EXP_UINT_TOP = 8'd158;

  typedef enum logic [3:0] {
    FPU_ADD    = 4'd0,
    FPU_SUB    = 4'd1,
    FPU_MUL    = 4'd2,
    FPU_FMA    = 4'd3,
    FPU_CVTWS  = 4'd4,
    FPU_CVTSW  = 4'd5,
    FPU_CVTWUS = 4'd6,
    FPU_CVTSWU = 4'd7
  } fpu_op_t;

  typedef struct packed {
    logic nv;
    logic nx;
  } cvt_flags_t;

  typedef struct packed {
    logic zero;
    logic nan;
    logic inf;
    logic neg;
  } cvt_class_t;

endpackage

// File: rtl/fp_convert_unsigned_pipe_lzc32.sv
// lzc32
//   Combinational 32-bit leading-zero count.
//   value : input word
//   count : number of leading zeros, 32 when value is all zero
module lzc32
  (
    input  logic [31:0] value,
    output logic [5:0]  count
  );

  // Ascending scan so the highest set bit is the last one to assign.
  always_comb begin
    count = 6'd32;
    for (int i = 0; i < 32; i++) begin
      if (value[i]) count = 6'(31 - i);
    end
  end

endmodule

// File: rtl/fp_convert_unsigned_pipe.sv
// fp_convert_unsigned_pipe
//   Two-stage FP32 <-> uint32 converter.
//     FPU_CVTWUS : FP32 -> uint32, truncate toward zero, saturating
//     FPU_CVTSWU : uint32 -> FP32, round to nearest even
//   S1 registers operand class, fields and leading-zero count; S2 registers
//   the final result. Latency 2, throughput 1, full backpressure.
//   Ports:
//     clk, rst                 clock, async active-high reset
//     in_valid/in_ready        input handshake (in_ready is combinational
//                              from out_ready; no skid buffer)
//     in_op, in_operand, in_tag  operation, operand bits, opaque tag
//     out_valid/out_ready      output handshake
//     out_result, out_tag      converted value and its tag
//     out_flags                {NV, NX}
//   Build option: define FP_CVT_FLAGS_EN to compute and deliver NV/NX;
//   otherwise out_flags is constant zero and no flag logic exists.
module fp_convert_unsigned_pipe
  import fp_convert_unsigned_pipe_pkg::*;
  #(
    parameter int TAG_WIDTH = 8
  )
  (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  fpu_op_t               in_op,
    input  logic [DATA_WIDTH-1:0] in_operand,
    input  logic [TAG_WIDTH-1:0]  in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_result,
    output logic [TAG_WIDTH-1:0]  out_tag,
    output logic [1:0]            out_flags
  );

  logic s1_valid;
  logic s1_adv;
  logic s2_adv;

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  // ---------------- S1 decode ----------------
  logic [5:0]  lzc_in;
  cvt_class_t  cls_in;
  logic [7:0]  exp_in;
  logic [22:0] man_in;

  assign exp_in = in_operand[30:23];
  assign man_in = in_operand[22:0];

  lzc32 u_lzc (
    .value (in_operand),
    .count (lzc_in)
  );

  always_comb begin
    cls_in = '0;
    if (in_op == FPU_CVTSWU) begin
      cls_in.zero = (in_operand == '0);
    end else begin
      cls_in.neg  = in_operand[31];
      cls_in.zero = (exp_in == 8'd0) && (man_in == '0);
      cls_in.nan  = (exp_in == FP32_EXP_MAX) && (man_in != '0);
      cls_in.inf  = (exp_in == FP32_EXP_MAX) && (man_in == '0);
    end
  end

  fpu_op_t                s1_op;
  logic [DATA_WIDTH-1:0]  s1_operand;
  logic [TAG_WIDTH-1:0]   s1_tag;
  logic [5:0]             s1_lzc;
  cvt_class_t             s1_cls;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_op      <= FPU_ADD;
      s1_operand <= '0;
      s1_tag     <= '0;
      s1_lzc     <= '0;
      s1_cls     <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_op      <= in_op;
        s1_operand <= in_operand;
        s1_tag     <= in_tag;
        s1_lzc     <= lzc_in;
        s1_cls     <= cls_in;
      end
    end
  end

  // ---------------- S2 compute ----------------
  logic [7:0]  s1_exp;
  logic [4:0]  wus_e;
  logic [31:0] wus_sig;
  logic [31:0] wus_shifted;
  logic [31:0] wus_res;
  logic [30:0] norm_frac;
  logic        guard;
  logic        sticky;
  logic        round_up;
  logic [23:0] mant_r;
  logic [7:0]  exp_r;
  logic [31:0] swu_res;
  logic [31:0] res_d;

  assign s1_exp  = s1_operand[30:23];
  // Unbiased exponent is only needed for 127..158, where (exp - 127) mod 32
  // equals exp[4:0] + 1.
  assign wus_e   = s1_operand[27:23] + 5'd1;
  assign wus_sig = {8'd0, 1'b1, s1_operand[22:0]};

  always_comb begin
    if (wus_e >= 5'd23) wus_shifted = wus_sig << (wus_e - 5'd23);
    else                wus_shifted = wus_sig >> (5'd23 - wus_e);
  end

  always_comb begin
    if (s1_cls.nan)                   wus_res = UINT32_MAX;
    else if (s1_cls.inf)              wus_res = s1_cls.neg ? '0 : UINT32_MAX;
    else if (s1_exp < FP32_BIAS)      wus_res = '0;
    else if (s1_cls.neg)              wus_res = '0;
    else if (s1_exp >= FP32_EXP_2P32) wus_res = UINT32_MAX;
    else                              wus_res = wus_shifted;
  end

  // Leading one sits at bit 31 after normalization and is dropped.
  assign norm_frac = 31'(s1_operand << s1_lzc);
  assign guard     = norm_frac[7];
  assign sticky    = |norm_frac[6:0];
  assign round_up  = guard && (sticky || norm_frac[8]);
  assign mant_r    = {1'b0, norm_frac[30:8]} + {23'd0, round_up};
  // Mantissa carry-out leaves mant_r[22:0] zero and bumps the exponent.
  assign exp_r     = FP32_EXP_UINT_TOP - {2'b00, s1_lzc} + {7'd0, mant_r[23]};
  assign swu_res   = {1'b0, exp_r, mant_r[22:0]};

  always_comb begin
    res_d = '0;
    case (s1_op)
      FPU_CVTWUS: res_d = wus_res;
      FPU_CVTSWU: res_d = s1_cls.zero ? '0 : swu_res;
      default:    res_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_tag    <= '0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_result <= res_d;
        out_tag    <= s1_tag;
      end
    end
  end

`ifdef FP_CVT_FLAGS_EN
  // NV is fully known from the operand class, so it is resolved in S1.
  logic       nv_in;
  logic       s1_nv;
  logic       nx_d;
  cvt_flags_t flags_q;

  always_comb begin
    nv_in = 1'b0;
    if (in_op == FPU_CVTWUS) begin
      nv_in = cls_in.nan || cls_in.inf ||
              (cls_in.neg && (exp_in >= FP32_BIAS)) ||
              (exp_in >= FP32_EXP_2P32);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      s1_nv <= 1'b0;
    else if (s1_adv && in_valid)  s1_nv <= nv_in;
  end

  always_comb begin
    nx_d = 1'b0;
    case (s1_op)
      FPU_CVTWUS: begin
        if (s1_cls.nan || s1_cls.inf)       nx_d = 1'b0;
        else if (s1_exp < FP32_BIAS)        nx_d = !s1_cls.zero;
        else if (s1_cls.neg)                nx_d = 1'b0;
        else if (s1_exp >= FP32_EXP_2P32)   nx_d = 1'b0;
        else if (wus_e < 5'd23)
          nx_d = |(wus_sig & ((32'd1 << (5'd23 - wus_e)) - 32'd1));
        else                                nx_d = 1'b0;
      end
      FPU_CVTSWU: nx_d = guard || sticky;
      default:    nx_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q <= '0;
    end else if (s2_adv && s1_valid) begin
      flags_q.nv <= s1_nv;
      flags_q.nx <= nx_d;
    end
  end

  assign out_flags = flags_q;
`else
  assign out_flags = 2'b00;
`endif

endmodule

// File: tb/tb_fp_convert_unsigned_pipe.sv
// Self-checking bench for fp_convert_unsigned_pipe: directed vectors,
// back-to-back streaming, stall, mid-flight reset and randomized traffic
// checked against an arithmetic reference model.
module tb_fp_convert_unsigned_pipe;
  import fp_convert_unsigned_pipe_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  fpu_op_t     in_op;
  logic [31:0] in_operand;
  logic [7:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [7:0]  out_tag;
  logic [1:0]  out_flags;

  fp_convert_unsigned_pipe #(.TAG_WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_operand (in_operand),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag),
    .out_flags  (out_flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [7:0]  tag;
    logic [1:0]  flags;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          fails  = 0;
  int          cyc    = 0;
  bit          lat_check = 0;
  bit          dir_en = 0;
  logic [31:0] dir_res;
  logic [1:0]  dir_flags;

  function automatic logic [1:0] fmask(input logic [1:0] f);
`ifdef FP_CVT_FLAGS_EN
    return f;
`else
    return 2'b00;
`endif
  endfunction

  // Reference model: value-level arithmetic on 64-bit integers.
  function automatic void model(input fpu_op_t op, input logic [31:0] x,
                                output logic [31:0] r, output logic [1:0] f);
    int unsigned ex, man, p, sh;
    longint unsigned full, q, rem, half;
    r = '0;
    f = 2'b00;
    ex  = 32'(x[30:23]);
    man = 32'(x[22:0]);
    if (op == FPU_CVTWUS) begin
      if (ex == 255 && man != 0)      begin r = 32'hFFFF_FFFF; f = 2'b10; end
      else if (ex == 255)             begin r = x[31] ? 32'd0 : 32'hFFFF_FFFF; f = 2'b10; end
      else if (ex < 127)              begin r = 32'd0; f = {1'b0, (ex != 0 || man != 0)}; end
      else if (x[31])                 begin r = 32'd0; f = 2'b10; end
      else if (ex >= 159)             begin r = 32'hFFFF_FFFF; f = 2'b10; end
      else begin
        full = ((64'd1 << 23) + 64'(man)) << (ex - 127);
        r = 32'(full >> 23);
        f = {1'b0, (full % (64'd1 << 23)) != 0};
      end
    end else if (op == FPU_CVTSWU) begin
      if (x != 0) begin
        p = 31;
        while (x[p] == 1'b0) p--;
        ex = 127 + p;
        if (p <= 23) begin
          q = (64'(x) << (23 - p));
          rem = 0;
        end else begin
          sh   = p - 23;
          q    = 64'(x) >> sh;
          rem  = 64'(x) - (q << sh);
          half = 64'd1 << (sh - 1);
          if (rem > half || (rem == half && q[0])) q = q + 1;
          if (q == (64'd1 << 24)) begin q = q >> 1; ex = ex + 1; end
        end
        r = {1'b0, ex[7:0], q[22:0]};
        f = {1'b0, rem != 0};
      end
    end
  endfunction

  task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    assert (got === expv) else begin
      fails++;
      $error("FAIL %s got=%h expected=%h", name, got, expv);
    end
  endtask

  // One clock: sample outputs on the falling edge, score accepts, then
  // return 1 time unit after the next rising edge for input driving.
  task automatic step();
    exp_t e;
    logic [31:0] r;
    logic [1:0]  f;
    @(negedge clk);
    cyc++;
    if (out_valid && out_ready) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        fails++;
        $error("FAIL spurious_output got tag=%h expected no output", out_tag);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk32("result", out_result, e.res);
        chk32("tag", 32'(out_tag), 32'(e.tag));
        chk32("flags", 32'(out_flags), 32'(e.flags));
        if (lat_check) chk32("latency", 32'(cyc - e.cyc), 32'd2);
      end
    end
    if (in_valid && in_ready && !rst) begin
      if (dir_en) begin
        r = dir_res;
        f = dir_flags;
      end else begin
        model(in_op, in_operand, r, f);
      end
      e.res = r; e.tag = in_tag; e.flags = fmask(f); e.cyc = cyc;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) step();
    chk32("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  typedef struct {
    fpu_op_t     op;
    logic [31:0] x;
    logic [31:0] r;
    logic [1:0]  f;
  } vec_t;

  vec_t vecs[$];

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_op = FPU_CVTWUS; in_operand = '0;
    in_tag = '0; out_ready = 1'b1;

    vecs.push_back('{FPU_CVTSWU, 32'hFFFF_FFFF, 32'h4F80_0000, 2'b01});
    vecs.push_back('{FPU_CVTSWU, 32'h0100_0001, 32'h4B80_0000, 2'b01});
    vecs.push_back('{FPU_CVTSWU, 32'h0100_0003, 32'h4B80_0002, 2'b01});
    vecs.push_back('{FPU_CVTSWU, 32'h0000_0000, 32'h0000_0000, 2'b00});
    vecs.push_back('{FPU_CVTSWU, 32'h0000_0001, 32'h3F80_0000, 2'b00});
    vecs.push_back('{FPU_CVTWUS, 32'h4F7F_FFFF, 32'hFFFF_FF00, 2'b00});
    vecs.push_back('{FPU_CVTWUS, 32'h4F80_0000, 32'hFFFF_FFFF, 2'b10});
    vecs.push_back('{FPU_CVTWUS, 32'h3FC0_0000, 32'h0000_0001, 2'b01});
    vecs.push_back('{FPU_CVTWUS, 32'hBF80_0000, 32'h0000_0000, 2'b10});
    vecs.push_back('{FPU_CVTWUS, 32'h7FC0_0000, 32'hFFFF_FFFF, 2'b10});
    vecs.push_back('{FPU_CVTWUS, 32'hFF80_0000, 32'h0000_0000, 2'b10});
    vecs.push_back('{FPU_CVTWUS, 32'h7F80_0000, 32'hFFFF_FFFF, 2'b10});
    vecs.push_back('{FPU_CVTWUS, 32'h8000_0000, 32'h0000_0000, 2'b00});
    vecs.push_back('{FPU_CVTWUS, 32'hBF00_0000, 32'h0000_0000, 2'b01});
    vecs.push_back('{FPU_CVTWUS, 32'h3F80_0000, 32'h0000_0001, 2'b00});
    vecs.push_back('{FPU_MUL,    32'h3F80_0000, 32'h0000_0000, 2'b00});

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk32("rst_out_valid", 32'(out_valid), 32'd0);
    chk32("rst_out_result", out_result, 32'd0);
    chk32("rst_out_tag", 32'(out_tag), 32'd0);
    chk32("rst_out_flags", 32'(out_flags), 32'd0);
    rst = 1'b0;
    #1;
    chk32("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Directed vectors, back to back, with constant expectations
    dir_en = 1'b1;
    lat_check = 1'b1;
    foreach (vecs[i]) begin
      in_valid = 1'b1; in_op = vecs[i].op; in_operand = vecs[i].x;
      in_tag = 8'(8'h40 + i);
      dir_res = vecs[i].r; dir_flags = vecs[i].f;
      step();
    end
    drain();
    dir_en = 1'b0;

    // Stream of 16 ops, out_ready held high: one result per cycle, latency 2
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_op = (i % 2 == 0) ? FPU_CVTSWU : FPU_CVTWUS;
      in_operand = $urandom;
      in_tag = 8'(i);
      #1;
      chk32("stream_in_ready", 32'(in_ready), 32'd1);
      step();
    end
    drain();
    lat_check = 1'b0;

    // Stall: out_ready low with a full pipe
    out_ready = 1'b0;
    for (int k = 0; k < 7; k++) begin
      in_valid = 1'b1; in_op = FPU_CVTSWU; in_operand = $urandom;
      in_tag = 8'(8'h80 + k);
      if (k >= 2) begin
        #1;
        chk32("stall_in_ready", 32'(in_ready), 32'd0);
        chk32("stall_out_valid", 32'(out_valid), 32'd1);
        if (exp_q.size() != 0) begin
          chk32("stall_result_hold", out_result, exp_q[0].res);
          chk32("stall_tag_hold", 32'(out_tag), 32'(exp_q[0].tag));
        end
      end
      step();
    end
    chk32("stall_buffered", 32'(exp_q.size()), 32'd2);
    drain();

    // Reset while both stages are valid
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1; in_op = FPU_CVTWUS; in_operand = 32'h4000_0000;
      in_tag = 8'(8'hC0 + k);
      step();
    end
    in_valid = 1'b0;
    chk32("pre_rst_out_valid", 32'(out_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk32("midrst_out_valid", 32'(out_valid), 32'd0);
    chk32("midrst_out_result", out_result, 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk32("after_rst_out_valid", 32'(out_valid), 32'd0);
      chk32("after_rst_in_ready", 32'(in_ready), 32'd1);
      step();
    end

    // Randomized traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      int unsigned sel;
      logic [31:0] x;
      in_valid = ($urandom_range(0, 3) != 0);
      sel = $urandom_range(0, 9);
      x = $urandom;
      if (sel < 5) begin
        in_op = FPU_CVTWUS;
        if ($urandom_range(0, 3) != 0) x[30:23] = 8'($urandom_range(115, 165));
      end else if (sel < 9) begin
        in_op = FPU_CVTSWU;
        if ($urandom_range(0, 1) != 0) x = x >> $urandom_range(0, 31);
      end else begin
        in_op = FPU_ADD;
      end
      in_operand = x;
      in_tag = 8'(i);
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
